// File: rtl/reorder_buffer_pkg.sv
// Shared sizes and types for the reorder buffer: tag/count widths and the entry record.
package reorder_buffer_pkg;

   localparam int ROB_DEPTH = 8;
   localparam int ROB_IX_W  = $clog2(ROB_DEPTH);
   localparam int XLEN      = 32;
   localparam int REG_W     = 5;

   typedef logic [ROB_IX_W-1:0] rob_ix_t;
   typedef logic [ROB_IX_W:0]   rob_count_t;
   typedef logic [XLEN-1:0]     xlen_t;
   typedef logic [REG_W-1:0]    reg_ix_t;

   typedef struct packed {
      logic    busy;
      logic    done;
      logic    has_dest;
      reg_ix_t rd;
      xlen_t   value;
   } rob_entry_t;

   // Per-entry payload kept apart from busy/done so it can live in reset-less storage.
   typedef struct packed {
      logic    has_dest;
      reg_ix_t rd;
      xlen_t   value;
   } rob_payload_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue / CDB / lookup / commit bundle between the Tomasulo core (master) and the ROB (slave).
interface reorder_buffer_if;
   import reorder_buffer_pkg::*;

   logic       alloc_valid_in;
   logic       alloc_has_dest_in;
   reg_ix_t    alloc_rd_in;
   logic       alloc_ready_out;
   rob_ix_t    alloc_rob_ix_out;

   rob_ix_t    src1_rob_ix_in;
   rob_ix_t    src2_rob_ix_in;
   logic       src1_ready_out;
   logic       src2_ready_out;
   xlen_t      src1_value_out;
   xlen_t      src2_value_out;

   logic       cdb_valid_in;
   rob_ix_t    cdb_rob_ix_in;
   xlen_t      cdb_value_in;

   logic       commit_valid_out;
   logic       commit_has_dest_out;
   reg_ix_t    commit_rd_out;
   xlen_t      commit_value_out;
   rob_ix_t    commit_rob_ix_out;
   rob_count_t count_out;

   modport master (
      output alloc_valid_in, alloc_has_dest_in, alloc_rd_in,
      output src1_rob_ix_in, src2_rob_ix_in,
      output cdb_valid_in, cdb_rob_ix_in, cdb_value_in,
      input  alloc_ready_out, alloc_rob_ix_out,
      input  src1_ready_out, src2_ready_out, src1_value_out, src2_value_out,
      input  commit_valid_out, commit_has_dest_out, commit_rd_out, commit_value_out,
      input  commit_rob_ix_out, count_out
   );

   modport slave (
      input  alloc_valid_in, alloc_has_dest_in, alloc_rd_in,
      input  src1_rob_ix_in, src2_rob_ix_in,
      input  cdb_valid_in, cdb_rob_ix_in, cdb_value_in,
      output alloc_ready_out, alloc_rob_ix_out,
      output src1_ready_out, src2_ready_out, src1_value_out, src2_value_out,
      output commit_valid_out, commit_has_dest_out, commit_rd_out, commit_value_out,
      output commit_rob_ix_out, count_out
   );

endinterface

// File: rtl/reorder_buffer_rob_ptr.sv
// Wrapping ROB index pointer; instantiated for the head (retire) and tail (allocate) positions.
module rob_ptr
   import reorder_buffer_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    inc,
   output rob_ix_t ptr
);

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      ptr <= '0;
      else if (inc) ptr <= ptr + rob_ix_t'(1);
   end

endmodule

// File: rtl/reorder_buffer.sv
// In-order completion buffer: allocates tags, captures CDB results, retires one entry per cycle.
// Optional macro ROB_CDB_BYPASS_EN forwards a same-cycle CDB result to the operand lookups.
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input  logic           clk_in,
   input  logic           rst_in,
   reorder_buffer_if.slave rob
);

   rob_ix_t          head_ix;
   rob_ix_t          tail_ix;
   rob_count_t       count_q;
   logic [ROB_DEPTH-1:0] busy_q;
   logic [ROB_DEPTH-1:0] done_q;
   rob_payload_t     payload_q [ROB_DEPTH];
   rob_entry_t       head_entry;

   logic alloc_ready;
   logic alloc_fire;
   logic commit_fire;
   logic cdb_accept;

   assign alloc_ready = (count_q < rob_count_t'(ROB_DEPTH));
   assign alloc_fire  = rob.alloc_valid_in && alloc_ready;
   assign cdb_accept  = rob.cdb_valid_in && busy_q[rob.cdb_rob_ix_in] && !done_q[rob.cdb_rob_ix_in];

   assign head_entry = '{busy:     busy_q[head_ix],
                         done:     done_q[head_ix],
                         has_dest: payload_q[head_ix].has_dest,
                         rd:       payload_q[head_ix].rd,
                         value:    payload_q[head_ix].value};
   assign commit_fire = head_entry.busy && head_entry.done;

   rob_ptr u_head (.clk(clk_in), .rst(rst_in), .inc(commit_fire), .ptr(head_ix));
   rob_ptr u_tail (.clk(clk_in), .rst(rst_in), .inc(alloc_fire),  .ptr(tail_ix));

   // Commit and alloc never target the same slot: a busy head implies tail != head unless full.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         busy_q <= '0;
         done_q <= '0;
      end else begin
         if (commit_fire) begin
            busy_q[head_ix] <= 1'b0;
            done_q[head_ix] <= 1'b0;
         end
         if (alloc_fire) begin
            busy_q[tail_ix] <= 1'b1;
            done_q[tail_ix] <= 1'b0;
         end
         if (cdb_accept) done_q[rob.cdb_rob_ix_in] <= 1'b1;
      end
   end

   // NOTE: payload storage has no reset; busy/done gate every read, so stale contents never escape.
   always_ff @(posedge clk_in) begin
      if (alloc_fire) begin
         payload_q[tail_ix].has_dest <= rob.alloc_has_dest_in;
         payload_q[tail_ix].rd       <= rob.alloc_rd_in;
      end
      if (cdb_accept) payload_q[rob.cdb_rob_ix_in].value <= rob.cdb_value_in;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         count_q                 <= '0;
         rob.commit_valid_out    <= 1'b0;
         rob.commit_has_dest_out <= 1'b0;
         rob.commit_rd_out       <= '0;
         rob.commit_value_out    <= '0;
         rob.commit_rob_ix_out   <= '0;
      end else begin
         count_q              <= count_q + rob_count_t'(alloc_fire) - rob_count_t'(commit_fire);
         rob.commit_valid_out <= commit_fire;
         if (commit_fire) begin
            rob.commit_has_dest_out <= head_entry.has_dest;
            rob.commit_rd_out       <= head_entry.rd;
            rob.commit_value_out    <= head_entry.value;
            rob.commit_rob_ix_out   <= head_ix;
         end
      end
   end

   assign rob.alloc_ready_out  = alloc_ready;
   assign rob.alloc_rob_ix_out = tail_ix;
   assign rob.count_out        = count_q;

   rob_ix_t src_ix    [2];
   logic    src_ready [2];
   xlen_t   src_value [2];

   assign src_ix[0] = rob.src1_rob_ix_in;
   assign src_ix[1] = rob.src2_rob_ix_in;

   // NOTE: every always_comb output gets a value on entry, so no path can infer a latch.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         src_ready[i] = busy_q[src_ix[i]] && done_q[src_ix[i]];
         src_value[i] = src_ready[i] ? payload_q[src_ix[i]].value : '0;
`ifdef ROB_CDB_BYPASS_EN
         // A stored result wins over a late broadcast, matching first-write-wins capture.
         if (!src_ready[i] && rob.cdb_valid_in && (rob.cdb_rob_ix_in == src_ix[i]) &&
             busy_q[src_ix[i]]) begin
            src_ready[i] = 1'b1;
            src_value[i] = rob.cdb_value_in;
         end
`endif
      end
   end

   assign rob.src1_ready_out = src_ready[0];
   assign rob.src1_value_out = src_value[0];
   assign rob.src2_ready_out = src_ready[1];
   assign rob.src2_value_out = src_value[1];

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed table, corner sequences and a randomized
// run against a queue-based program-order model.
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;

   reorder_buffer_if rob_bus ();

   reorder_buffer dut (
      .clk_in (clk),
      .rst_in (rst),
      .rob    (rob_bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic    alloc_v;
      logic    has_dest;
      reg_ix_t rd;
      logic    cdb_v;
      rob_ix_t cdb_ix;
      xlen_t   cdb_val;
      rob_ix_t s1;
      rob_ix_t s2;
      logic    exp_cv;
      rob_ix_t exp_ix;
      logic    exp_hd;
      xlen_t   exp_val;
      rob_count_t exp_count;
   } vec_t;

   typedef struct {
      rob_ix_t tag;
      logic    has_dest;
      reg_ix_t rd;
      logic    done;
      xlen_t   value;
   } m_entry_t;

   // Reference model: program-order queue of in-flight instructions plus the last retire.
   m_entry_t mq [$];
   int       next_tag;
   logic     m_cv;
   rob_ix_t  m_ix;
   logic     m_hd;
   reg_ix_t  m_rd;
   xlen_t    m_val;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic vec_t mk(int a, int hd, int rd, int c, int ix, int val,
                               int ecv, int eix, int ehd, int evl, int ecnt);
      vec_t v;
      v.alloc_v   = a[0];
      v.has_dest  = hd[0];
      v.rd        = reg_ix_t'(rd);
      v.cdb_v     = c[0];
      v.cdb_ix    = rob_ix_t'(ix);
      v.cdb_val   = xlen_t'(val);
      v.s1        = rob_ix_t'(ix);
      v.s2        = rob_ix_t'(eix);
      v.exp_cv    = ecv[0];
      v.exp_ix    = rob_ix_t'(eix);
      v.exp_hd    = ehd[0];
      v.exp_val   = xlen_t'(evl);
      v.exp_count = rob_count_t'(ecnt);
      return v;
   endfunction

   function automatic void model_reset();
      mq.delete();
      next_tag = 0;
      m_cv = 1'b0; m_ix = '0; m_hd = 1'b0; m_rd = '0; m_val = '0;
   endfunction

   function automatic void m_lookup(input rob_ix_t ix, input vec_t v,
                                    output logic rdy, output xlen_t val);
      rdy = 1'b0;
      val = '0;
      foreach (mq[k]) begin
         if (mq[k].tag == ix) begin
            if (mq[k].done) begin
               rdy = 1'b1;
               val = mq[k].value;
            end
`ifdef ROB_CDB_BYPASS_EN
            else if (v.cdb_v && v.cdb_ix == ix) begin
               rdy = 1'b1;
               val = v.cdb_val;
            end
`endif
         end
      end
   endfunction

   // One clock edge of the architectural rules: retire oldest if finished, capture CDB once, allocate.
   function automatic void model_edge(input vec_t v);
      logic     do_commit;
      logic     do_alloc;
      m_entry_t e;
      do_commit = (mq.size() > 0) && mq[0].done;
      do_alloc  = v.alloc_v && (mq.size() < ROB_DEPTH);
      if (v.cdb_v) begin
         foreach (mq[k])
            if (mq[k].tag == v.cdb_ix && !mq[k].done) begin
               mq[k].done  = 1'b1;
               mq[k].value = v.cdb_val;
            end
      end
      m_cv = do_commit;
      if (do_commit) begin
         e = mq.pop_front();
         m_ix = e.tag; m_hd = e.has_dest; m_rd = e.rd; m_val = e.value;
      end
      if (do_alloc) begin
         e.tag = rob_ix_t'(next_tag); e.has_dest = v.has_dest; e.rd = v.rd;
         e.done = 1'b0; e.value = '0;
         mq.push_back(e);
         next_tag = (next_tag + 1) % ROB_DEPTH;
      end
   endfunction

   task automatic drive(input vec_t v);
      rob_bus.alloc_valid_in    = v.alloc_v;
      rob_bus.alloc_has_dest_in = v.has_dest;
      rob_bus.alloc_rd_in       = v.rd;
      rob_bus.cdb_valid_in      = v.cdb_v;
      rob_bus.cdb_rob_ix_in     = v.cdb_ix;
      rob_bus.cdb_value_in      = v.cdb_val;
      rob_bus.src1_rob_ix_in    = v.s1;
      rob_bus.src2_rob_ix_in    = v.s2;
   endtask

   // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
   task automatic apply(input vec_t v);
      logic  r1, r2;
      xlen_t v1, v2;
      drive(v);
      #2;
      m_lookup(v.s1, v, r1, v1);
      m_lookup(v.s2, v, r2, v2);
      check("alloc_ready", rob_bus.alloc_ready_out, (mq.size() < ROB_DEPTH));
      check("alloc_ix",    rob_bus.alloc_rob_ix_out, next_tag);
      check("src1_ready",  rob_bus.src1_ready_out, r1);
      check("src1_value",  rob_bus.src1_value_out, v1);
      check("src2_ready",  rob_bus.src2_ready_out, r2);
      check("src2_value",  rob_bus.src2_value_out, v2);
      model_edge(v);
      @(posedge clk);
      #1;
      check("commit_valid", rob_bus.commit_valid_out, m_cv);
      if (m_cv) begin
         check("commit_ix",    rob_bus.commit_rob_ix_out, m_ix);
         check("commit_hd",    rob_bus.commit_has_dest_out, m_hd);
         check("commit_value", rob_bus.commit_value_out, m_val);
         if (m_hd) check("commit_rd", rob_bus.commit_rd_out, m_rd);
      end
      check("count", rob_bus.count_out, mq.size());
   endtask

   task automatic reset_dut();
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #2;
      rst = 1'b1;
      #1;
      check("rst_commit_valid", rob_bus.commit_valid_out, 0);
      check("rst_count",        rob_bus.count_out, 0);
      check("rst_alloc_ix",     rob_bus.alloc_rob_ix_out, 0);
      check("rst_alloc_ready",  rob_bus.alloc_ready_out, 1);
      check("rst_commit_value", rob_bus.commit_value_out, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   vec_t tbl [21];

   initial begin
      vec_t v;

      // Directed table: in-order retire of out-of-order results, store retire, first-write-wins.
      tbl[0]  = mk(1, 1, 1, 0, 0, 0,     0, 0, 0, 0,     1);
      tbl[1]  = mk(1, 1, 2, 0, 0, 0,     0, 0, 0, 0,     2);
      tbl[2]  = mk(1, 1, 3, 0, 0, 0,     0, 0, 0, 0,     3);
      tbl[3]  = mk(0, 0, 0, 1, 2, 30,    0, 0, 0, 0,     3);
      tbl[4]  = mk(0, 0, 0, 1, 0, 10,    0, 0, 0, 0,     3);
      tbl[5]  = mk(0, 0, 0, 1, 1, 20,    1, 0, 1, 10,    2);
      tbl[6]  = mk(0, 0, 0, 0, 0, 0,     1, 1, 1, 20,    1);
      tbl[7]  = mk(0, 0, 0, 0, 0, 0,     1, 2, 1, 30,    0);
      tbl[8]  = mk(0, 0, 0, 0, 0, 0,     0, 0, 0, 0,     0);
      tbl[9]  = mk(1, 0, 7, 0, 0, 0,     0, 0, 0, 0,     1);
      tbl[10] = mk(0, 0, 0, 1, 3, 'h66,  0, 0, 0, 0,     1);
      tbl[11] = mk(0, 0, 0, 0, 0, 0,     1, 3, 0, 'h66,  0);
      tbl[12] = mk(1, 1, 4, 0, 0, 0,     0, 0, 0, 0,     1);
      tbl[13] = mk(1, 1, 5, 0, 0, 0,     0, 0, 0, 0,     2);
      tbl[14] = mk(0, 0, 0, 1, 5, 'h11,  0, 0, 0, 0,     2);
      tbl[15] = mk(0, 0, 0, 1, 5, 'h22,  0, 0, 0, 0,     2);
      tbl[16] = mk(0, 0, 0, 1, 4, 'h44,  0, 0, 0, 0,     2);
      tbl[17] = mk(0, 0, 0, 0, 0, 0,     1, 4, 1, 'h44,  1);
      tbl[18] = mk(0, 0, 0, 0, 0, 0,     1, 5, 1, 'h11,  0);
      tbl[19] = mk(0, 0, 0, 1, 5, 'h99,  0, 0, 0, 0,     0);
      tbl[20] = mk(0, 0, 0, 0, 0, 0,     0, 0, 0, 0,     0);

      model_reset();
      reset_dut();

      for (int i = 0; i < 21; i++) begin
         apply(tbl[i]);
         check($sformatf("tbl%0d_cv", i), rob_bus.commit_valid_out, tbl[i].exp_cv);
         if (tbl[i].exp_cv) begin
            check($sformatf("tbl%0d_ix", i),  rob_bus.commit_rob_ix_out, tbl[i].exp_ix);
            check($sformatf("tbl%0d_hd", i),  rob_bus.commit_has_dest_out, tbl[i].exp_hd);
            check($sformatf("tbl%0d_val", i), rob_bus.commit_value_out, tbl[i].exp_val);
         end
         check($sformatf("tbl%0d_count", i), rob_bus.count_out, tbl[i].exp_count);
      end

      // Full buffer: 9th alloc dropped, freed slot not reusable until the following cycle.
      reset_dut();
      for (int i = 0; i < ROB_DEPTH; i++) apply(mk(1, 1, i + 8, 0, 0, 0, 0, 0, 0, 0, 0));
      check("full_ready", rob_bus.alloc_ready_out, 0);
      check("full_count", rob_bus.count_out, 8);
      apply(mk(1, 1, 20, 1, 0, 'hA0, 0, 0, 0, 0, 0));
      check("drop_count",   rob_bus.count_out, 8);
      check("drop_tail",    rob_bus.alloc_rob_ix_out, 0);
      check("drop_ready",   rob_bus.alloc_ready_out, 0);
      apply(mk(1, 1, 21, 0, 0, 0, 0, 0, 0, 0, 0));
      check("free_cv",      rob_bus.commit_valid_out, 1);
      check("free_value",   rob_bus.commit_value_out, 'hA0);
      check("free_count",   rob_bus.count_out, 7);
      check("free_ready",   rob_bus.alloc_ready_out, 1);
      check("wrap_tag",     rob_bus.alloc_rob_ix_out, 0);
      apply(mk(1, 1, 22, 0, 0, 0, 0, 0, 0, 0, 0));
      check("refill_count", rob_bus.count_out, 8);

      // Lookup of a pending tag in the same cycle its result is broadcast.
      reset_dut();
      for (int i = 0; i < 4; i++) apply(mk(1, 1, i, 0, 0, 0, 0, 0, 0, 0, 0));
      v = mk(0, 0, 0, 1, 3, 'h55, 0, 0, 0, 0, 0);
      drive(v);
      #2;
`ifdef ROB_CDB_BYPASS_EN
      check("bypass_ready", rob_bus.src1_ready_out, 1);
      check("bypass_value", rob_bus.src1_value_out, 'h55);
`else
      check("bypass_ready", rob_bus.src1_ready_out, 0);
      check("bypass_value", rob_bus.src1_value_out, 0);
`endif
      apply(v);
      v = mk(0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
      drive(v);
      #2;
      check("stored_ready", rob_bus.src1_ready_out, 1);
      check("stored_value", rob_bus.src1_value_out, 'h55);
      apply(v);

      // Randomized traffic with one asynchronous reset mid-run.
      reset_dut();
      for (int i = 0; i < 1500; i++) begin
         if (i == 700) reset_dut();
         v.alloc_v  = ($urandom_range(0, 99) < 55);
         v.has_dest = ($urandom_range(0, 3) != 0);
         v.rd       = reg_ix_t'($urandom);
         v.cdb_v    = ($urandom_range(0, 99) < 70);
         if (mq.size() > 0 && $urandom_range(0, 9) < 8)
            v.cdb_ix = mq[$urandom_range(0, mq.size() - 1)].tag;
         else
            v.cdb_ix = rob_ix_t'($urandom);
         v.cdb_val  = xlen_t'($urandom);
         v.s1       = ($urandom_range(0, 1) == 0) ? v.cdb_ix : rob_ix_t'($urandom);
         v.s2       = rob_ix_t'($urandom);
         apply(v);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
